// File: rtl/tms1x00_prog_loader.sv
// Wishbone loader for port 0 of the TMS1x00 program SRAM.
// Holds the core in reset while firmware is written and blocks writes once it runs.
module tms1x00_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        sram_csb0,
    output logic        sram_web0,
    output logic [3:0]  sram_wmask0,
    output logic [8:0]  sram_addr0,
    output logic [31:0] sram_din0,
    input  logic [31:0] sram_dout0,
    output logic        cpu_rst_o,
    output logic [9:0]  load_count_o
);

    typedef enum logic [1:0] {IDLE, ACC, RD, ACK} state_t;

    state_t      state_q;
    logic        cpu_rst_q;
    logic        wr_blocked_q;
    logic [9:0]  load_count_q;
    logic [9:0]  load_count_d;
    logic        csb0_q;
    logic        web0_q;
    logic [3:0]  wmask0_q;
    logic [8:0]  addr0_q;
    logic [31:0] din0_q;
    logic [31:0] dat_q;
    logic [31:0] reg_rdata;
    logic        hit;
    logic        is_ctrl;
    logic        is_stat;
    logic        unused_ok;

    assign hit     = wbs_cyc_i & wbs_stb_i
                   & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign is_ctrl = (wbs_adr_i[11:0] == 12'h800);
    assign is_stat = (wbs_adr_i[11:0] == 12'h804);

    assign unused_ok = ^wbs_adr_i[1:0];

    assign load_count_d = (load_count_q == 10'h3FF) ? load_count_q
                                                    : load_count_q + 10'd1;

    always_comb begin
        reg_rdata = '0;
        if (is_ctrl) begin
            reg_rdata = {30'd0, wr_blocked_q, cpu_rst_q};
        end else if (is_stat) begin
            reg_rdata = {22'd0, load_count_q};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            cpu_rst_q    <= 1'b1;
            wr_blocked_q <= 1'b0;
            load_count_q <= '0;
            csb0_q       <= 1'b1;
            web0_q       <= 1'b1;
            wmask0_q     <= '0;
            addr0_q      <= '0;
            din0_q       <= '0;
            dat_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (!wbs_adr_i[11]) begin
                            addr0_q  <= wbs_adr_i[10:2];
                            din0_q   <= wbs_dat_i;
                            wmask0_q <= wbs_sel_i;
                            web0_q   <= ~wbs_we_i;
                            // A running core must never see its program change.
                            if (wbs_we_i && !cpu_rst_q) begin
                                csb0_q       <= 1'b1;
                                wr_blocked_q <= 1'b1;
                            end else begin
                                csb0_q <= 1'b0;
                            end
                            state_q <= ACC;
                        end else begin
                            if (wbs_we_i) begin
                                if (is_ctrl) begin
                                    cpu_rst_q <= wbs_dat_i[0];
                                    if (wbs_dat_i[1]) begin
                                        wr_blocked_q <= 1'b0;
                                    end
                                end
                                if (is_stat) begin
                                    load_count_q <= '0;
                                end
                            end else begin
                                dat_q <= reg_rdata;
                            end
                            state_q <= ACK;
                        end
                    end
                end
                ACC: begin
                    csb0_q <= 1'b1;
                    web0_q <= 1'b1;
                    if (!csb0_q && !web0_q) begin
                        load_count_q <= load_count_d;
                    end
                    state_q <= web0_q ? RD : ACK;
                end
                RD: begin
                    dat_q   <= sram_dout0;
                    state_q <= ACK;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o    = (state_q == ACK) & wbs_cyc_i & wbs_stb_i;
    assign wbs_dat_o    = dat_q;
    assign sram_csb0    = csb0_q;
    assign sram_web0    = web0_q;
    assign sram_wmask0  = wmask0_q;
    assign sram_addr0   = addr0_q;
    assign sram_din0    = din0_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign load_count_o = load_count_q;

endmodule

// File: tb/tb_tms1x00_prog_loader.sv
// Directed bench for tms1x00_prog_loader with a behavioural SRAM on port 0.
// Vector table for single transactions, hand sequences for reset and saturation.
module tb_tms1x00_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0, dout0;
    logic        cpu_rst;
    logic [9:0]  lcount;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem [512];
    logic [8:0]  cap_addr;
    logic        cap_web;
    logic [31:0] cap_din;

    always #5 clk = ~clk;

    tms1x00_prog_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .sram_csb0(csb0), .sram_web0(web0), .sram_wmask0(wmask0),
        .sram_addr0(addr0), .sram_din0(din0), .sram_dout0(dout0),
        .cpu_rst_o(cpu_rst), .load_count_o(lcount)
    );

    // Port-0 SRAM: samples controls at the clock edge, read data registered.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int lat, output int csb_n,
                       output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; csb_n = 0; rd = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!csb0) begin
                csb_n++;
                cap_addr = addr0; cap_web = web0; cap_din = din0;
            end
            if (ack) begin
                lat = i;
                rd = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        int          csb;
        logic        chk_rd;
        logic [31:0] rd;
        logic        cpu;
        logic [9:0]  lc;
    } vec_t;

    localparam logic [31:0] B = 32'h3000_0000;
    vec_t v [22];

    initial begin
        int lat, csbn;
        logic [31:0] rd;
        logic bad;

        v[0]  = '{1'b0, B+32'h010, 32'h0, 4'hF, 3, 1, 1'b1, 32'hDEADBEEF, 1'b1, 10'd1};
        v[1]  = '{1'b0, B+32'h804, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1, 1'b1, 10'd1};
        v[2]  = '{1'b0, B+32'h800, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1, 1'b1, 10'd1};
        v[3]  = '{1'b1, B+32'h800, 32'h0, 4'hF, 1, 0, 1'b0, 32'h0, 1'b0, 10'd1};
        v[4]  = '{1'b1, B+32'h000, 32'h12345678, 4'hF, 2, 0, 1'b0, 32'h0, 1'b0, 10'd1};
        v[5]  = '{1'b0, B+32'h800, 32'h0, 4'hF, 1, 0, 1'b1, 32'h2, 1'b0, 10'd1};
        v[6]  = '{1'b0, B+32'h804, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1, 1'b0, 10'd1};
        v[7]  = '{1'b0, B+32'h010, 32'h0, 4'hF, 3, 1, 1'b1, 32'hDEADBEEF, 1'b0, 10'd1};
        v[8]  = '{1'b1, B+32'h800, 32'h3, 4'hF, 1, 0, 1'b0, 32'h0, 1'b1, 10'd1};
        v[9]  = '{1'b0, B+32'h800, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1, 1'b1, 10'd1};
        v[10] = '{1'b0, B+32'h900, 32'h0, 4'hF, 1, 0, 1'b1, 32'h0, 1'b1, 10'd1};
        v[11] = '{1'b1, B+32'h900, 32'hFFFFFFFF, 4'hF, 1, 0, 1'b0, 32'h0, 1'b1, 10'd1};
        v[12] = '{1'b0, B+32'h800, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1, 1'b1, 10'd1};
        v[13] = '{1'b1, B+32'h010, 32'h0, 4'h0, 2, 1, 1'b0, 32'h0, 1'b1, 10'd2};
        v[14] = '{1'b0, B+32'h010, 32'h0, 4'hF, 3, 1, 1'b1, 32'hDEADBEEF, 1'b1, 10'd2};
        v[15] = '{1'b1, B+32'h010, 32'h00001111, 4'h3, 2, 1, 1'b0, 32'h0, 1'b1, 10'd3};
        v[16] = '{1'b0, B+32'h010, 32'h0, 4'hF, 3, 1, 1'b1, 32'hDEAD1111, 1'b1, 10'd3};
        v[17] = '{1'b0, B+32'h804, 32'h0, 4'hF, 1, 0, 1'b1, 32'h3, 1'b1, 10'd3};
        v[18] = '{1'b1, B+32'h804, 32'h0, 4'hF, 1, 0, 1'b0, 32'h0, 1'b1, 10'd0};
        v[19] = '{1'b0, 32'h3000_1000, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1, 10'd0};
        v[20] = '{1'b1, 32'h2FFF_F000, 32'h5, 4'hF, 0, 0, 1'b0, 32'h0, 1'b1, 10'd0};
        v[21] = '{1'b0, B+32'h010, 32'h0, 4'hF, 3, 1, 1'b1, 32'hDEAD1111, 1'b1, 10'd0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = '0; adr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (csb0 !== 1'b1 || ack !== 1'b0 || cpu_rst !== 1'b1 || lcount !== 10'd0)
                bad = 1'b1;
        end
        chk("reset_idle", {31'd0, bad}, 32'd0);
        chk("reset_outs", {web0, wmask0, addr0, din0 == 0, rdat == 0},
            {1'b1, 4'h0, 9'h0, 1'b1, 1'b1});

        bus(1'b1, B+32'h010, 32'hDEADBEEF, 4'hF, lat, csbn, rd);
        chk("wr_lat", lat, 2);
        chk("wr_csb_cycles", csbn, 1);
        chk("wr_addr0", {23'd0, cap_addr}, 32'd4);
        chk("wr_web0", {31'd0, cap_web}, 32'd0);
        chk("wr_din0", cap_din, 32'hDEADBEEF);
        chk("wr_count", {22'd0, lcount}, 32'd1);

        for (int i = 0; i < 22; i++) begin
            bus(v[i].w, v[i].a, v[i].d, v[i].s, lat, csbn, rd);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_csb", i), csbn, v[i].csb);
            if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, v[i].cpu});
            chk($sformatf("v%0d_count", i), {22'd0, lcount}, {22'd0, v[i].lc});
        end

        for (int i = 0; i < 1030; i++)
            bus(1'b1, B + 32'(i % 512) * 4, 32'(i), 4'hF, lat, csbn, rd);
        chk("sat_count", {22'd0, lcount}, 32'd1023);
        bus(1'b1, B+32'h804, 32'h0, 4'hF, lat, csbn, rd);
        chk("status_clear", {22'd0, lcount}, 32'd0);

        bus(1'b1, B+32'h000, 32'hCAFEF00D, 4'hF, lat, csbn, rd);
        bus(1'b0, B+32'h000, 32'h0, 4'hF, lat, csbn, rd);
        chk("pre_rst_rdata", rd, 32'hCAFEF00D);
        bus(1'b1, B+32'h800, 32'h0, 4'hF, lat, csbn, rd);
        chk("pre_rst_cpu", {31'd0, cpu_rst}, 32'd0);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B + 32'h004; sel = 4'hF;
        @(negedge clk);
        chk("rd_acc_csb", {31'd0, csb0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_csb", {31'd0, csb0}, 32'd1);
        chk("rst_outs", {web0, wmask0, addr0, cpu_rst},
            {1'b1, 4'h0, 9'h0, 1'b1});
        chk("rst_din", din0, 32'd0);
        chk("rst_rdat", rdat, 32'd0);
        chk("rst_count", {22'd0, lcount}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack !== 1'b0 || csb0 !== 1'b1) bad = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, bad}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
